active_list_commit_sequencer: RTL and testbench

Consumer-side controller for the active list. It reads the head execution states and valid-entry count, and decides each cycle how many head entries retire (`popHeadNum`). When it detects a flush-causing op, it sequences the tail-side rollback (`popTailNum`) until the flushed entries are drained. It sits between the active list and the commit stage / rename-logic committer and is the single source of both pop counts.

---
 rtl/active_list_commit_sequencer_if.sv | 42 ++++
 rtl/active_list_commit_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_active_list_commit_sequencer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/active_list_commit_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : active_list_commit_sequencer_if
// Description : Bundle between the active list / commit stage and the commit
//               sequencer. The master drives the head states and occupancy;
//               the slave (sequencer) returns both pop counts and the
//               recovery status.
// Revision    : 1.0 - initial release
// ============================================================================
interface active_list_commit_sequencer_if #(
    parameter int COMMIT_WIDTH          = 2,
    parameter int ACTIVE_LIST_ENTRY_NUM = 64
);
    localparam int VALID_W = $clog2(ACTIVE_LIST_ENTRY_NUM) + 1;
    localparam int POP_W   = $clog2(COMMIT_WIDTH + 1);
    localparam int LANE_W  = (COMMIT_WIDTH > 1) ? $clog2(COMMIT_WIDTH) : 1;

    logic [COMMIT_WIDTH-1:0][2:0] headExecState;
    logic [VALID_W-1:0]           validEntryNum;
    logic                         stall;
    logic [POP_W-1:0]             popHeadNum;
    logic [POP_W-1:0]             popTailNum;
    logic [COMMIT_WIDTH-1:0]      commitLaneValid;
    logic                         recoveryTrigger;
    logic [2:0]                   recoveryCause;
    logic [LANE_W-1:0]            recoveryLane;
    logic                         inRecovery;
    logic                         recoveryDone;

    modport master (
        output headExecState, validEntryNum, stall,
        input  popHeadNum, popTailNum, commitLaneValid, recoveryTrigger,
               recoveryCause, recoveryLane, inRecovery, recoveryDone
    );

    modport slave (
        input  headExecState, validEntryNum, stall,
        output popHeadNum, popTailNum, commitLaneValid, recoveryTrigger,
               recoveryCause, recoveryLane, inRecovery, recoveryDone
    );
endinterface
`default_nettype wire

// File: rtl/active_list_commit_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : active_list_commit_sequencer
// Description : Decides per cycle how many active-list head entries retire
//               and, after a flush-causing op, drains the younger entries
//               from the tail COMMIT_WIDTH at a time.
//               Optional feature macro: RSD_COMMIT_SEQ_PERF_COUNTER_EN adds
//               32-bit commit / flush accumulators.
// Revision    : 1.0 - initial release
// ============================================================================
module active_list_commit_sequencer #(
    parameter int COMMIT_WIDTH          = 2,
    parameter int ACTIVE_LIST_ENTRY_NUM = 64
) (
    input wire clk,
    input wire rst,  // synchronous, active-low
    active_list_commit_sequencer_if.slave bus
`ifdef RSD_COMMIT_SEQ_PERF_COUNTER_EN
    ,
    output logic [31:0] perfCommitCount,
    output logic [31:0] perfFlushCount
`endif
);
    localparam int VALID_W = $clog2(ACTIVE_LIST_ENTRY_NUM) + 1;
    localparam int POP_W   = $clog2(COMMIT_WIDTH + 1);
    localparam int LANE_W  = (COMMIT_WIDTH > 1) ? $clog2(COMMIT_WIDTH) : 1;

    localparam logic [VALID_W-1:0] c_ENTRY_NUM = VALID_W'(ACTIVE_LIST_ENTRY_NUM);
    localparam logic [VALID_W-1:0] c_WIDTH     = VALID_W'(COMMIT_WIDTH);

    localparam logic [2:0] c_NOT_FINISHED = 3'd0;
    localparam logic [2:0] c_SUCCESS      = 3'd1;
    localparam logic [2:0] c_REFETCH_THIS = 3'd2;
    localparam logic [2:0] c_REFETCH_NEXT = 3'd3;
    localparam logic [2:0] c_MISPRED      = 3'd4;
    localparam logic [2:0] c_TRAP         = 3'd5;

    typedef enum logic [0:0] {
        S_COMMIT   = 1'b0,
        S_ROLLBACK = 1'b1
    } state_t;

    state_t             r_state;
    logic [VALID_W-1:0] r_rem;
    logic [POP_W-1:0]   r_popTailNum;
    logic               r_inRecovery;
    logic               r_recoveryDone;

    logic [VALID_W-1:0]      w_validNum;
    logic [VALID_W-1:0]      w_newRem;
    logic [VALID_W-1:0]      w_nextRem;
    logic [COMMIT_WIDTH-1:0] w_laneValid;
    logic [POP_W-1:0]        w_popHeadNum;
    logic                    w_trigger;
    logic [2:0]              w_cause;
    logic [LANE_W-1:0]       w_lane;
    logic                    w_scan;

    // Tail pops per rollback cycle are capped at the lane count.
    function automatic logic [POP_W-1:0] capPop(input logic [VALID_W-1:0] n);
        return (n < c_WIDTH) ? POP_W'(n) : POP_W'(COMMIT_WIDTH);
    endfunction

    assign w_validNum = (bus.validEntryNum > c_ENTRY_NUM) ? c_ENTRY_NUM : bus.validEntryNum;
    assign w_newRem   = w_validNum - VALID_W'(w_popHeadNum);
    assign w_nextRem  = r_rem - c_WIDTH;

    // Oldest-first head scan: stops at an unfinished op, the end of the
    // occupied region, or the first flush-causing op.
    always_comb begin
        w_laneValid = '0;
        w_trigger   = 1'b0;
        w_cause     = 3'd0;
        w_lane      = '0;
        w_scan      = 1'b1;
        if (rst && (r_state == S_COMMIT) && !bus.stall) begin
            for (int i = 0; i < COMMIT_WIDTH; i++) begin
                if (w_scan) begin
                    if (VALID_W'(i) >= w_validNum) begin
                        w_scan = 1'b0;
                    end else begin
                        case (bus.headExecState[i])
                            c_NOT_FINISHED: w_scan = 1'b0;
                            c_SUCCESS:      w_laneValid[i] = 1'b1;
                            c_REFETCH_NEXT, c_MISPRED: begin
                                // Op itself completes; younger ops are flushed.
                                w_laneValid[i] = 1'b1;
                                w_trigger      = 1'b1;
                                w_cause        = bus.headExecState[i];
                                w_lane         = LANE_W'(i);
                                w_scan         = 1'b0;
                            end
                            c_REFETCH_THIS: begin
                                w_trigger = 1'b1;
                                w_cause   = c_REFETCH_THIS;
                                w_lane    = LANE_W'(i);
                                w_scan    = 1'b0;
                            end
                            default: begin
                                // Codes 5..7 all behave as a trap.
                                w_trigger = 1'b1;
                                w_cause   = c_TRAP;
                                w_lane    = LANE_W'(i);
                                w_scan    = 1'b0;
                            end
                        endcase
                    end
                end
            end
        end
    end

    // Retire count is the population of the prefix mask.
    always_comb begin
        w_popHeadNum = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            w_popHeadNum = w_popHeadNum + POP_W'(w_laneValid[i]);
        end
    end

    // Commit/rollback FSM; tail-pop outputs are precomputed one cycle ahead
    // so each rollback cycle presents its own pop count from a register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= S_COMMIT;
            r_rem          <= '0;
            r_popTailNum   <= '0;
            r_inRecovery   <= 1'b0;
            r_recoveryDone <= 1'b0;
        end else begin
            case (r_state)
                S_COMMIT: begin
                    if (w_trigger) begin
                        r_state        <= S_ROLLBACK;
                        r_rem          <= w_newRem;
                        r_popTailNum   <= capPop(w_newRem);
                        r_recoveryDone <= (w_newRem <= c_WIDTH);
                        r_inRecovery   <= 1'b1;
                    end
                end
                S_ROLLBACK: begin
                    if (r_recoveryDone) begin
                        r_state        <= S_COMMIT;
                        r_rem          <= '0;
                        r_popTailNum   <= '0;
                        r_recoveryDone <= 1'b0;
                        r_inRecovery   <= 1'b0;
                    end else begin
                        r_rem          <= w_nextRem;
                        r_popTailNum   <= capPop(w_nextRem);
                        r_recoveryDone <= (w_nextRem <= c_WIDTH);
                    end
                end
                default: r_state <= S_COMMIT;
            endcase
        end
    end

    assign bus.popHeadNum      = w_popHeadNum;
    assign bus.commitLaneValid = w_laneValid;
    assign bus.recoveryTrigger = w_trigger;
    assign bus.recoveryCause   = w_cause;
    assign bus.recoveryLane    = w_lane;
    assign bus.popTailNum      = r_popTailNum;
    assign bus.inRecovery      = r_inRecovery;
    assign bus.recoveryDone    = r_recoveryDone;

`ifdef RSD_COMMIT_SEQ_PERF_COUNTER_EN
    // Free-running accumulators of retired and rolled-back entries.
    always_ff @(posedge clk) begin
        if (!rst) begin
            perfCommitCount <= '0;
            perfFlushCount  <= '0;
        end else begin
            perfCommitCount <= perfCommitCount + 32'(w_popHeadNum);
            perfFlushCount  <= perfFlushCount + 32'(r_popTailNum);
        end
    end
`endif
endmodule
`default_nettype wire

// File: tb/tb_active_list_commit_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_active_list_commit_sequencer
// Description : Directed plus randomized bench for the commit sequencer,
//               checked every cycle against a queue-free behavioural model
//               (scan rules + remaining-entry count), with literal checks on
//               the documented scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_active_list_commit_sequencer;
    localparam int CW = 2;
    localparam int N  = 64;
    localparam int VW = $clog2(N) + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    active_list_commit_sequencer_if #(.COMMIT_WIDTH(CW), .ACTIVE_LIST_ENTRY_NUM(N)) ifc ();

`ifdef RSD_COMMIT_SEQ_PERF_COUNTER_EN
    logic [31:0] perfCommitCount;
    logic [31:0] perfFlushCount;
`endif

    active_list_commit_sequencer #(.COMMIT_WIDTH(CW), .ACTIVE_LIST_ENTRY_NUM(N)) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc)
`ifdef RSD_COMMIT_SEQ_PERF_COUNTER_EN
        ,
        .perfCommitCount(perfCommitCount),
        .perfFlushCount(perfFlushCount)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Model state: are we draining, and how many flushed entries remain.
    bit          mRollback = 1'b0;
    int          mRem      = 0;
    logic [31:0] mCommitSum = '0;
    logic [31:0] mFlushSum  = '0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Evaluate the retire/flush rules for the current inputs, compare, then
    // advance the model as the coming clock edge will.
    task automatic model_check();
        int ven, st, expLv, expPop, expTrig, expCause, expLane, expTail, expDone;
        bit stop;
        expLv = 0; expTrig = 0; expCause = 0; expLane = 0; stop = 1'b0;
        ven = (int'(ifc.validEntryNum) > N) ? N : int'(ifc.validEntryNum);
        if (rst && !mRollback && !ifc.stall) begin
            for (int i = 0; i < CW; i++) begin
                if (!stop) begin
                    st = int'(ifc.headExecState[i]);
                    if (i >= ven || st == 0) stop = 1'b1;
                    else if (st == 1) expLv |= (1 << i);
                    else begin
                        expTrig  = 1;
                        expLane  = i;
                        expCause = (st >= 5) ? 5 : st;
                        if (st == 3 || st == 4) expLv |= (1 << i);
                        stop = 1'b1;
                    end
                end
            end
        end
        expPop  = $countones(expLv);
        expTail = mRollback ? ((mRem < CW) ? mRem : CW) : 0;
        expDone = (mRollback && mRem <= CW) ? 1 : 0;

        chk("commitLaneValid", int'(ifc.commitLaneValid), expLv);
        chk("popHeadNum", int'(ifc.popHeadNum), expPop);
        chk("recoveryTrigger", int'(ifc.recoveryTrigger), expTrig);
        if (expTrig != 0) begin
            chk("recoveryCause", int'(ifc.recoveryCause), expCause);
            chk("recoveryLane", int'(ifc.recoveryLane), expLane);
        end
        chk("popTailNum", int'(ifc.popTailNum), expTail);
        chk("inRecovery", int'(ifc.inRecovery), int'(mRollback));
        chk("recoveryDone", int'(ifc.recoveryDone), expDone);
`ifdef RSD_COMMIT_SEQ_PERF_COUNTER_EN
        chk("perfCommitCount", int'(perfCommitCount), int'(mCommitSum));
        chk("perfFlushCount", int'(perfFlushCount), int'(mFlushSum));
`endif

        if (!rst) begin
            mRollback = 1'b0; mRem = 0; mCommitSum = '0; mFlushSum = '0;
        end else begin
            mCommitSum = mCommitSum + 32'(expPop);
            mFlushSum  = mFlushSum + 32'(expTail);
            if (mRollback) begin
                if (mRem <= CW) begin mRollback = 1'b0; mRem = 0; end
                else mRem = mRem - CW;
            end else if (expTrig != 0) begin
                mRollback = 1'b1;
                mRem = ven - expPop;
            end
        end
    endtask

    // One cycle: drive inputs just after the edge, check at the falling edge.
    task automatic step(input bit r, input int ven, input int s0, input int s1, input bit st);
        @(posedge clk);
        #1;
        rst = r;
        ifc.validEntryNum    = VW'(ven);
        ifc.headExecState[0] = 3'(s0);
        ifc.headExecState[1] = 3'(s1);
        ifc.stall            = st;
        @(negedge clk);
        model_check();
    endtask

    function automatic int randState();
        int p;
        p = int'($urandom_range(0, 99));
        if (p < 65) return 1;
        if (p < 75) return 0;
        return int'($urandom_range(2, 7));
    endfunction

    initial begin
        rst = 1'b0;
        ifc.validEntryNum = '0;
        ifc.headExecState = '0;
        ifc.stall = 1'b0;

        // Reset: combinational outputs forced low despite committable inputs.
        step(0, 5, 1, 1, 0);
        step(0, 5, 1, 1, 0);
        chk("rst_popHead", int'(ifc.popHeadNum), 0);
        chk("rst_laneValid", int'(ifc.commitLaneValid), 0);
        chk("rst_inRecovery", int'(ifc.inRecovery), 0);
        chk("rst_popTail", int'(ifc.popTailNum), 0);

        // Plain retirement.
        step(1, 5, 1, 1, 0); chk("s1_pop", int'(ifc.popHeadNum), 2);
        step(1, 3, 1, 1, 0); chk("s1_pop2", int'(ifc.popHeadNum), 2);
        step(1, 1, 1, 1, 0); chk("s1_pop3", int'(ifc.popHeadNum), 1);
        chk("s1_lv3", int'(ifc.commitLaneValid), 1);

        // Blocked head and stall.
        step(1, 5, 0, 1, 0); chk("nf_pop", int'(ifc.popHeadNum), 0);
        chk("nf_lv", int'(ifc.commitLaneValid), 0);
        step(1, 5, 1, 1, 1); chk("stall_pop", int'(ifc.popHeadNum), 0);

        // Mispredict in lane 1: rem = 5 -> tail pops 2,2,1.
        step(1, 7, 1, 4, 0);
        chk("mp_pop", int'(ifc.popHeadNum), 2);
        chk("mp_trig", int'(ifc.recoveryTrigger), 1);
        chk("mp_cause", int'(ifc.recoveryCause), 4);
        chk("mp_lane", int'(ifc.recoveryLane), 1);
        step(1, 7, 1, 1, 0); chk("mp_t1", int'(ifc.popTailNum), 2);
        chk("mp_inrec", int'(ifc.inRecovery), 1);
        chk("mp_pop_rb", int'(ifc.popHeadNum), 0);
        step(1, 7, 1, 1, 0); chk("mp_t2", int'(ifc.popTailNum), 2);
        chk("mp_d2", int'(ifc.recoveryDone), 0);
        step(1, 7, 1, 1, 0); chk("mp_t3", int'(ifc.popTailNum), 1);
        chk("mp_d3", int'(ifc.recoveryDone), 1);
        step(1, 3, 1, 1, 0); chk("mp_resume", int'(ifc.popHeadNum), 2);
        chk("mp_inrec_off", int'(ifc.inRecovery), 0);

        // Refetch-this at lane 0: nothing retires, rem = 4.
        step(1, 4, 2, 1, 0);
        chk("rt_pop", int'(ifc.popHeadNum), 0);
        chk("rt_cause", int'(ifc.recoveryCause), 2);
        step(1, 4, 1, 1, 0); chk("rt_t1", int'(ifc.popTailNum), 2);
        step(1, 4, 1, 1, 0); chk("rt_done", int'(ifc.recoveryDone), 1);
        step(1, 4, 5, 1, 0); chk("trap_cause", int'(ifc.recoveryCause), 5);
        step(1, 4, 1, 1, 0);
        step(1, 4, 1, 1, 0);
        step(1, 4, 1, 7, 0);
        chk("code7_cause", int'(ifc.recoveryCause), 5);
        chk("code7_pop", int'(ifc.popHeadNum), 1);
        step(1, 4, 1, 1, 0); step(1, 4, 1, 1, 0);

        // Refetch-next on the last entry: rem = 0, single empty rollback cycle.
        step(1, 1, 3, 5, 0);
        chk("rn_pop", int'(ifc.popHeadNum), 1);
        chk("rn_cause", int'(ifc.recoveryCause), 3);
        step(1, 1, 1, 1, 0);
        chk("rn_tail", int'(ifc.popTailNum), 0);
        chk("rn_done", int'(ifc.recoveryDone), 1);

        // Reset in the first rollback cycle of a rem=10 flush.
        step(1, 12, 1, 4, 0);
        step(0, 12, 1, 1, 0); chk("ab_tail_hold", int'(ifc.popTailNum), 2);
        step(1, 2, 1, 1, 0);
        chk("ab_tail", int'(ifc.popTailNum), 0);
        chk("ab_done", int'(ifc.recoveryDone), 0);
        chk("ab_inrec", int'(ifc.inRecovery), 0);
        chk("ab_pop", int'(ifc.popHeadNum), 2);

        // Empty list ignores even flush-causing states.
        step(1, 0, 4, 4, 0);
        chk("empty_trig", int'(ifc.recoveryTrigger), 0);

        // Saturated occupancy: rem = 64 - 1 = 63 -> 32 rollback cycles.
        step(1, 100, 1, 2, 0);
        chk("sat_pop", int'(ifc.popHeadNum), 1);
        for (int k = 0; k < 31; k++) step(1, 100, 1, 1, 0);
        step(1, 100, 1, 1, 0);
        chk("sat_last_tail", int'(ifc.popTailNum), 1);
        chk("sat_done", int'(ifc.recoveryDone), 1);

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(0, 99) != 0, int'($urandom_range(0, 70)),
                 randState(), randState(), $urandom_range(0, 9) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
